// File: rtl/wbr_cell_bank_o.sv
// Bank of WIDTH IEEE 1500 output-type wrapper boundary cells: one serial shift
// chain, a parallel update stage, safe/mode muxing on cfo and a shift counter.
module wbr_cell_bank_o #(
  parameter int unsigned          WIDTH    = 8,
  parameter logic [WIDTH-1:0]     SAFE_VAL = '0,
  parameter int unsigned          CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] cfi,
  output logic [WIDTH-1:0] cfo,
  input  logic             cti,
  output logic             cto,
  input  logic             shift,
  input  logic             capture,
  input  logic             transfer,
  input  logic             update,
  input  logic             io_face,
  input  logic             mode,
  input  logic             safe,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             vec_loaded
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] sh_q,  sh_d;
  logic [WIDTH-1:0] upd_q, upd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   chain_ext;
  logic [WIDTH-1:0] sh_shifted;

  // Widening by one bit keeps the shift expression legal for WIDTH=1.
  assign chain_ext  = {cti, sh_q};
  assign sh_shifted = chain_ext[WIDTH:1];

  assign cfo = mode ? (safe ? SAFE_VAL : upd_q) : cfi;

  // Shift stage priority: shift > capture > transfer > hold.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    upd_d = upd_q;
    if (shift) begin
      sh_d = sh_shifted;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (capture) begin
      sh_d  = io_face ? cfo : cfi;
      cnt_d = '0;
    end else if (transfer) begin
      sh_d  = upd_q;
      cnt_d = '0;
    end
    if (update) begin
      upd_d = sh_q;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sh_q  <= '0;
      upd_q <= SAFE_VAL;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      upd_q <= upd_d;
      cnt_q <= cnt_d;
    end
  end

  assign cto        = sh_q[0];
  assign shift_cnt  = cnt_q;
  assign vec_loaded = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_wbr_cell_bank_o.sv
// Directed, table-driven bench for wbr_cell_bank_o (WIDTH=8, SAFE_VAL=8'hA5).
module tb_wbr_cell_bank_o;

  logic       clk;
  logic       arst_n;
  logic [7:0] cfi;
  logic [7:0] cfo;
  logic       cti;
  logic       cto;
  logic       shift;
  logic       capture;
  logic       transfer;
  logic       update;
  logic       io_face;
  logic       mode;
  logic       safe;
  logic [3:0] shift_cnt;
  logic       vec_loaded;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sh;
    logic       cap;
    logic       xfr;
    logic       upd;
    logic       io;
    logic       md;
    logic       sf;
    logic       ti;
    logic [7:0] fi;
    logic [7:0] e_cfo;
    logic       e_cto;
    logic [3:0] e_cnt;
    logic       e_vl;
  } vec_t;

  vec_t vq[$];

  wbr_cell_bank_o #(
    .WIDTH   (8),
    .SAFE_VAL(8'hA5)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .cfi       (cfi),
    .cfo       (cfo),
    .cti       (cti),
    .cto       (cto),
    .shift     (shift),
    .capture   (capture),
    .transfer  (transfer),
    .update    (update),
    .io_face   (io_face),
    .mode      (mode),
    .safe      (safe),
    .shift_cnt (shift_cnt),
    .vec_loaded(vec_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic sh, input logic cap, input logic xfr, input logic upd,
                     input logic io, input logic md, input logic sf, input logic ti,
                     input logic [7:0] fi, input logic [7:0] e_cfo, input logic e_cto,
                     input logic [3:0] e_cnt, input logic e_vl);
    vec_t v;
    v.sh = sh; v.cap = cap; v.xfr = xfr; v.upd = upd;
    v.io = io; v.md = md; v.sf = sf; v.ti = ti; v.fi = fi;
    v.e_cfo = e_cfo; v.e_cto = e_cto; v.e_cnt = e_cnt; v.e_vl = e_vl;
    vq.push_back(v);
  endtask

  task automatic drive_idle();
    shift = 1'b0; capture = 1'b0; transfer = 1'b0; update = 1'b0;
    io_face = 1'b0; cti = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;

    // Shift in 8'h96 LSB first; update lands on the ninth shift (old sh = 96).
    pat = 8'h96;
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 0, 0, 1, 0, pat[i], 8'h3C, 8'hA5, 1'b0, 4'(i + 1), i == 7);
    add(1, 0, 0, 1, 0, 1, 0, 1, 8'h3C, 8'h96, 1'b1, 4'd8, 1'b1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 8'h3C, 8'hA5, 1'b1, 4'd8, 1'b1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 8'h3C, 8'h96, 1'b1, 4'd8, 1'b1);
    // Inward capture of cfi=5A, then shift it out.
    add(0, 1, 0, 0, 0, 1, 0, 0, 8'h5A, 8'h96, 1'b0, 4'd0, 1'b0);
    pat = 8'h5A;
    for (int k = 1; k <= 8; k++)
      add(1, 0, 0, 0, 0, 1, 0, 0, 8'h5A, 8'h96, (k < 8) ? pat[k] : 1'b0, 4'(k), k == 8);
    // Outward capture picks cfo=96 although cfi=5A.
    add(0, 1, 0, 0, 1, 1, 0, 0, 8'h5A, 8'h96, 1'b0, 4'd0, 1'b0);
    pat = 8'h96;
    for (int k = 1; k <= 8; k++)
      add(1, 0, 0, 0, 1, 1, 0, 0, 8'h5A, 8'h96, (k < 8) ? pat[k] : 1'b0, 4'(k), k == 8);
    // Transfer and priority corners.
    add(0, 1, 0, 0, 0, 1, 0, 0, 8'h0F, 8'h96, 1'b1, 4'd0, 1'b0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 8'h0F, 8'h0F, 1'b1, 4'd0, 1'b0);
    add(0, 1, 0, 0, 0, 1, 0, 0, 8'hF0, 8'h0F, 1'b0, 4'd0, 1'b0);
    add(1, 0, 0, 0, 0, 1, 0, 1, 8'hF0, 8'h0F, 1'b0, 4'd1, 1'b0);
    add(0, 0, 1, 0, 0, 1, 0, 0, 8'hF0, 8'h0F, 1'b1, 4'd0, 1'b0);
    add(1, 1, 1, 0, 0, 1, 0, 0, 8'hF0, 8'h0F, 1'b1, 4'd1, 1'b0);
    add(1, 0, 0, 0, 0, 1, 0, 0, 8'hF0, 8'h0F, 1'b1, 4'd2, 1'b0);
    add(0, 1, 1, 0, 0, 1, 0, 0, 8'hF0, 8'h0F, 1'b0, 4'd0, 1'b0);
    add(1, 0, 0, 1, 0, 1, 0, 1, 8'hF0, 8'hF0, 1'b0, 4'd1, 1'b0);
    // Functional mode ignores safe.
    add(0, 0, 0, 0, 0, 0, 1, 0, 8'hC3, 8'hC3, 1'b0, 4'd1, 1'b0);

    // Reset and functional pass-through.
    drive_idle();
    mode = 1'b0; safe = 1'b0; cfi = 8'h3C;
    arst_n = 1'b0;
    #2;
    check("rst_cto", 8'(cto), 8'h00);
    check("rst_cnt", 8'(shift_cnt), 8'h00);
    check("rst_vl", 8'(vec_loaded), 8'h00);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
    check("func_cfo", cfo, 8'h3C);
    mode = 1'b1;
    #1;
    check("test_cfo_rst_upd", cfo, 8'hA5);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      shift = vq[i].sh; capture = vq[i].cap; transfer = vq[i].xfr; update = vq[i].upd;
      io_face = vq[i].io; mode = vq[i].md; safe = vq[i].sf; cti = vq[i].ti; cfi = vq[i].fi;
      @(posedge clk); #1;
      check($sformatf("v%0d_cfo", i), cfo, vq[i].e_cfo);
      check($sformatf("v%0d_cto", i), 8'(cto), 8'(vq[i].e_cto));
      check($sformatf("v%0d_cnt", i), 8'(shift_cnt), 8'(vq[i].e_cnt));
      check($sformatf("v%0d_vl", i), 8'(vec_loaded), 8'(vq[i].e_vl));
    end

    // Asynchronous reset in the middle of a shift sequence.
    @(negedge clk);
    drive_idle();
    mode = 1'b1; safe = 1'b0; capture = 1'b1; cfi = 8'hFF;
    @(negedge clk);
    drive_idle();
    shift = 1'b1; cti = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_cnt3", 8'(shift_cnt), 8'h03);
    check("mid_cto", 8'(cto), 8'h01);
    shift = 1'b0;
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_cnt", 8'(shift_cnt), 8'h00);
    check("arst_cto", 8'(cto), 8'h00);
    check("arst_cfo", cfo, 8'hA5);
    @(negedge clk);
    arst_n = 1'b1;
    shift = 1'b1; cti = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cnt", 8'(shift_cnt), 8'h01);
    check("post_rst_cto", 8'(cto), 8'h00);
    drive_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbr_cell_bank_o.md
Name: wbr_cell_bank_o

Overview:
- Parametrised bank of WIDTH IEEE 1500 output-type wrapper boundary cells.
- Each cell has a shift stage and an update stage; all shift stages form one serial chain between cti and cto.
- Adds the features a single shift-only cell lacks:
  - update stage driving the functional output;
  - safe-state and mode muxing;
  - inward/outward capture select (io_face);
  - transfer (reload shift stage from update stage);
  - shift-count tracking.
- Sits between core functional outputs and the wrapper boundary; instantiated once per output port group.

Parameters:
- WIDTH, 8, number of boundary cells (1..64).
- SAFE_VAL, {WIDTH{1'b0}}, value driven on cfo when mode=1 and safe=1; also the reset value of the update stage.
- CNT_W, $clog2(WIDTH+1), width of shift_cnt (derived; do not override).

Ports:
- clk  in  1  wrapper clock; all state on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- cfi  in  WIDTH  functional data from core.
- cfo  out  WIDTH  functional data to boundary.
- cti  in  1  serial test input; enters cell WIDTH-1.
- cto  out  1  serial test output = shift stage bit 0.
- shift  in  1  shift chain one position toward bit 0.
- capture  in  1  parallel capture into shift stage.
- transfer  in  1  parallel load shift stage from update stage.
- update  in  1  load update stage from shift stage.
- io_face  in  1  0 = inward (capture cfi), 1 = outward (capture cfo).
- mode  in  1  0 = functional (cfo=cfi), 1 = test (cfo from update/safe).
- safe  in  1  in test mode, force cfo=SAFE_VAL.
- shift_cnt  out  CNT_W  shifts since last capture/transfer, saturating at WIDTH.
- vec_loaded  out  1  high when shift_cnt == WIDTH.

Behaviour:
- Reset (arst_n=0, immediate, asynchronous):
  - shift stage = 0, update stage = SAFE_VAL, shift_cnt = 0.
  - Hence cto = 0 and vec_loaded = 0; cfo follows the combinational mux.
- Shift-stage next value, strict priority:
  1. shift: sh <= {cti, sh[WIDTH-1:1]}.
  2. capture: sh <= io_face ? cfo : cfi. Uses current-cycle cfo (pre-edge update stage).
  3. transfer: sh <= upd.
  4. Otherwise hold.
- Lower-priority controls asserted with a higher one are ignored for the shift stage.
- Update stage: when update=1, upd <= sh (pre-edge value). This is independent of shift/capture/transfer in the same cycle, so update+shift loads the old sh while sh shifts.
- cfo (combinational): mode=0 -> cfi; mode=1 and safe=1 -> SAFE_VAL; mode=1 and safe=0 -> upd. safe is ignored when mode=0.
- cto = sh[0] (registered); first cti bit appears on cto WIDTH edges after it is shifted in.
- shift_cnt:
  - Effective shift -> min(shift_cnt+1, WIDTH).
  - Effective capture or transfer (no shift) -> 0.
  - Otherwise hold.
  - Saturates at WIDTH; no wrap.
- vec_loaded = (shift_cnt == WIDTH), combinational from the register.
- WIDTH=1: shift makes sh <= cti; shift_cnt saturates at 1 after one shift.
- Reset mid-shift: all state is forced immediately. Release is synchronous-safe: the first edge after deassert acts normally.
- No X propagation from unused controls; all controls are fully decoded.

Test Plan:
- Reset and functional pass-through: WIDTH=8, SAFE_VAL=8'hA5; assert arst_n=0 -> cto=0, shift_cnt=0, vec_loaded=0. Release with mode=0, cfi=8'h3C -> cfo=8'h3C; set mode=1, safe=0 -> cfo=8'hA5 (reset update value).
- Shift-in and update: shift 8 cycles with serial bits forming 8'h96 (LSB first) -> shift_cnt 1..8 then vec_loaded=1. Ninth shift keeps shift_cnt=8. Pulse update with mode=1 -> cfo=8'h96; safe=1 -> cfo=8'hA5.
- Capture both faces:
  - mode=1, upd=8'h96, cfi=8'h5A, io_face=0, capture -> sh=8'h5A and shift_cnt=0; shift out 8 cycles -> cto yields 0,1,0,1,1,0,1,0.
  - Repeat with io_face=1 -> sh=8'h96.
- Transfer and priority:
  - upd=8'h0F, transfer -> sh=8'h0F, shift_cnt=0.
  - shift+capture+transfer together -> only shift occurs and shift_cnt increments.
  - update+shift same edge -> upd gets pre-shift sh.
- Async reset mid-operation: after 3 shifts (shift_cnt=3), drop arst_n between edges -> sh=0, upd=8'hA5, shift_cnt=0 immediately without a clock edge. Release; next shift -> shift_cnt=1.
